// File: rtl/op_pkg.sv
// Shared types and constants for the streaming element-wise adder and its result memory.
package op_pkg;

    localparam int unsigned DEF_MEM_WIDTH = 32;
    localparam int unsigned DEF_MEM_DEPTH = 8;

    // Address width for a memory of the given depth; depth is at least 2.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/result_store.sv
// Result memory: writes data_i to addr_i on every clock edge while out of reset.
module result_store
    import op_pkg::*;
#(
    parameter  int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
    parameter  int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    localparam int unsigned ADDR_W    = addr_w(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MEM_WIDTH-1:0] data_i,
    input  logic [ADDR_W-1:0]    addr_i
);

    logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            mem[addr_i] <= data_i;
        end
    end

endmodule

// File: rtl/operation_engine.sv
// Streaming element-wise adder: sweeps operand addresses 0..MEM_DEPTH-1 once after reset
// and presents one registered sum with its write address per cycle.
module operation_engine
    import op_pkg::*;
#(
    parameter  int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
    parameter  int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    localparam int unsigned ADDR_W    = addr_w(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MEM_WIDTH-1:0] operand1_i,
    input  logic [MEM_WIDTH-1:0] operand2_i,
    output logic [ADDR_W-1:0]    operand1_addr_o,
    output logic [ADDR_W-1:0]    operand2_addr_o,
    output logic [ADDR_W-1:0]    result_addr_o,
    output logic [MEM_WIDTH-1:0] result_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]    result_addr_q, result_addr_d;
    logic [MEM_WIDTH-1:0] result_q, result_d;

    // Two's-complement add; the carry out is dropped by keeping only MEM_WIDTH bits.
    function automatic logic [MEM_WIDTH-1:0] wrap_add(
        input logic signed [MEM_WIDTH-1:0] a,
        input logic signed [MEM_WIDTH-1:0] b
    );
        logic signed [MEM_WIDTH-1:0] sum;
        sum = a + b;
        return sum;
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        result_addr_d = result_addr_q;
        result_d      = result_q;
        case (state_q)
            RUN: begin
                result_d      = wrap_add(operand1_i, operand2_i);
                result_addr_d = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // DONE holds everything so the store keeps rewriting the last element.
            DONE:    ;
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            idx_q         <= '0;
            result_addr_q <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            result_addr_q <= result_addr_d;
            result_q      <= result_d;
        end
    end

    assign operand1_addr_o = idx_q;
    assign operand2_addr_o = idx_q;
    assign result_addr_o   = result_addr_q;
    assign result_o        = result_q;

endmodule

// File: tb/tb_operation_engine.sv
// Scoreboard bench for operation_engine with a sibling result_store, as at integration level.
module tb_operation_engine;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  operand1, operand2, result;
    logic [AW-1:0] operand1_addr, operand2_addr, result_addr;

    logic [W-1:0]  op1_mem [D];
    logic [W-1:0]  op2_mem [D];
    logic [W-1:0]  exp_mem [D];

    exp_t sb_q[$];
    exp_t hold_e;
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;

    always #5 clk = ~clk;

    assign operand1 = op1_mem[operand1_addr];
    assign operand2 = op2_mem[operand2_addr];

    operation_engine #(.MEM_WIDTH(W), .MEM_DEPTH(D)) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .operand1_i     (operand1),
        .operand2_i     (operand2),
        .operand1_addr_o(operand1_addr),
        .operand2_addr_o(operand2_addr),
        .result_addr_o  (result_addr),
        .result_o       (result)
    );

    result_store #(.MEM_WIDTH(W), .MEM_DEPTH(D)) u_store (
        .clk_i (clk),
        .rst_ni(rst_n),
        .data_i(result),
        .addr_i(result_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Monitor: the engine presents a result every cycle once released.
    always @(negedge clk) begin
        int exp_idx;
        exp_t e;
        if (rst_n) begin
            if (edges == 0) begin
                check("pre_edge1_result", 64'(result), 64'd0);
                check("pre_edge1_op_addr", 64'(operand1_addr), 64'd0);
            end else begin
                exp_idx = (edges >= D - 1) ? D - 1 : edges;
                check("op1_addr", 64'(operand1_addr), 64'(exp_idx));
                check("op2_addr", 64'(operand2_addr), 64'(exp_idx));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("result_addr", 64'(result_addr), 64'(e.addr));
                    check("result", 64'(result), 64'(e.data));
                    hold_e = e;
                end else begin
                    check("hold_result_addr", 64'(result_addr), 64'(hold_e.addr));
                    check("hold_result", 64'(result), 64'(hold_e.data));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_expected();
        sb_q.delete();
        for (int i = 0; i < D; i++) begin
            sb_q.push_back('{addr: AW'(i), data: exp_mem[i]});
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < D; i++) begin
            check($sformatf("%s[%0d]", tag, i), 64'(u_store.mem[i]), 64'(exp_mem[i]));
        end
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_result_addr"}, 64'(result_addr), 64'd0);
        check({tag, "_op1_addr"}, 64'(operand1_addr), 64'd0);
        check({tag, "_op2_addr"}, 64'(operand2_addr), 64'd0);
        for (int i = 0; i < D; i++) begin
            check($sformatf("%s_mem[%0d]", tag, i), 64'(u_store.mem[i]), 64'd0);
        end
    endtask

    task automatic run_sweep(input string tag);
        rst_n = 1'b0;
        tick(2);
        check_in_reset({tag, "_rst"});
        push_expected();
        rst_n = 1'b1;
        tick(D + 2);
        check({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
        check_mem({tag, "_mem"});
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            op1_mem[i] = W'(i + 1);
            op2_mem[i] = W'(D - i);
            exp_mem[i] = 32'd9;
        end
        #1 rst_n = 1'b0;

        // Ascending plus descending operands: every sum is 9.
        run_sweep("ramp");
        tick(20);
        check("hold_op1_addr", 64'(operand1_addr), 64'd7);
        check("hold_op2_addr", 64'(operand2_addr), 64'd7);
        check_mem("ramp_hold_mem");

        // Signed, cancelling, overflowing and wrapping operands.
        op1_mem[0] = -32'sd3;         op2_mem[0] = -32'sd9;   exp_mem[0] = 32'hFFFF_FFF4;
        op1_mem[1] = -32'sd5;         op2_mem[1] = 32'sd5;    exp_mem[1] = 32'h0000_0000;
        op1_mem[2] = 32'hFFFF_FFFF;   op2_mem[2] = 32'd2;     exp_mem[2] = 32'h0000_0001;
        op1_mem[3] = 32'd100;         op2_mem[3] = -32'sd40;  exp_mem[3] = 32'h0000_003C;
        op1_mem[4] = 32'h7FFF_FFFF;   op2_mem[4] = 32'd1;     exp_mem[4] = 32'h8000_0000;
        op1_mem[5] = 32'd0;           op2_mem[5] = 32'd0;     exp_mem[5] = 32'h0000_0000;
        op1_mem[6] = 32'd10;          op2_mem[6] = 32'd20;    exp_mem[6] = 32'h0000_001E;
        op1_mem[7] = 32'hFFFF_FFFF;   op2_mem[7] = 32'hFFFF_FFFF; exp_mem[7] = 32'hFFFF_FFFE;
        run_sweep("signed");

        // Reset four edges into a sweep, held for two cycles, then a full restart.
        rst_n = 1'b0;
        tick(2);
        push_expected();
        rst_n = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_in_reset("midrst_a");
        tick(2);
        check_in_reset("midrst_b");
        push_expected();
        rst_n = 1'b1;
        tick(D + 2);
        check("midrst_sb_drained", 64'(sb_q.size()), 64'd0);
        check_mem("midrst_mem");
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
